// File: rtl/mem_access_unit.sv
// Byte/half/word load-store alignment between the memory stage and a 64x32 word memory.
// Loads and word stores: 0 cycles (combinational); byte/half stores: 2 cycles (read, then merged write).
// Backpressure: Stall is high for the first cycle of an aligned sub-word store; misaligned requests never stall.
module mem_access_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       StoreData,
    output logic [31:0]       LoadData,
    output logic              Stall,
    output logic              Misaligned,
    output logic [7:0]        MisCount,
    output logic [ADDR_W-3:0] MemA,
    output logic              MemWE,
    output logic [31:0]       MemWD,
    input  logic [31:0]       MemRD
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state;
    logic [31:0]       merged;
    logic [ADDR_W-3:0] waddr;

    logic        req;
    logic        is_word;
    logic        is_half;
    logic        misal;
    logic        sub_store;
    logic [4:0]  byte_lsb;
    logic [4:0]  half_lsb;
    logic [7:0]  lbyte;
    logic [15:0] lhalf;
    logic [31:0] merge_w;

    // Request decode: size class, misalignment, and whether a read-modify-write starts now
    always_comb begin
        req       = MemRead | MemWrite;
        is_word   = Size[1];
        is_half   = (Size == 2'b01);
        misal     = req && ((is_half && Addr[0]) || (is_word && (Addr[1:0] != 2'b00)));
        sub_store = (state == IDLE) && MemWrite && !is_word && !misal;
        byte_lsb  = {Addr[1:0], 3'b000};
        half_lsb  = {Addr[1], 4'b0000};
    end

    // Load extraction: pick the addressed byte/half of the read word and extend it
    always_comb begin
        lbyte    = MemRD[byte_lsb +: 8];
        lhalf    = MemRD[half_lsb +: 16];
        LoadData = 32'd0;
        if (MemRead && !misal) begin
            if (is_word)
                LoadData = MemRD;
            else if (is_half)
                LoadData = {{16{!Unsigned & lhalf[15]}}, lhalf};
            else
                LoadData = {{24{!Unsigned & lbyte[7]}}, lbyte};
        end
    end

    // Store merge: old word with the target byte/half replaced by the right-aligned store data
    always_comb begin
        merge_w = MemRD;
        if (is_half)
            merge_w[half_lsb +: 16] = StoreData[15:0];
        else
            merge_w[byte_lsb +: 8] = StoreData[7:0];
    end

    // Memory-side outputs; WRITE replays the captured merge, reset suppresses any write
    always_comb begin
        Misaligned = misal;
        Stall      = !RST && sub_store;
        MemA       = (state == WRITE) ? waddr : Addr[ADDR_W-1:2];
        MemWD      = (state == WRITE) ? merged : StoreData;
        MemWE      = !RST && ((state == WRITE) ||
                              ((state == IDLE) && MemWrite && is_word && !misal));
    end

    // Sub-word store sequencer: capture merged word and address, then write it next cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            merged <= 32'd0;
            waddr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sub_store) begin
                        merged <= merge_w;
                        waddr  <= Addr[ADDR_W-1:2];
                        state  <= WRITE;
                    end
                end
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating count of misaligned requests seen while idle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            MisCount <= 8'd0;
        else if (misal && (state == IDLE) && (MisCount != 8'hFF))
            MisCount <= MisCount + 8'd1;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        CLK;
    logic        RST;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [7:0]  Addr;
    logic [31:0] StoreData;
    logic [31:0] LoadData;
    logic        Stall;
    logic        Misaligned;
    logic [7:0]  MisCount;
    logic [5:0]  MemA;
    logic        MemWE;
    logic [31:0] MemWD;
    logic [31:0] MemRD;

    int errors = 0;
    int checks = 0;

    // Environment: 64x32 word memory with async read, plus a preload port
    logic [31:0] mem [64];
    logic        pre_we;
    logic [5:0]  pre_a;
    logic [31:0] pre_d;

    assign MemRD = mem[MemA];

    always @(posedge CLK) begin
        if (pre_we)
            mem[pre_a] <= pre_d;
        else if (MemWE)
            mem[MemA] <= MemWD;
    end

    mem_access_unit #(.ADDR_W(8)) dut (
        .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .Size(Size),
        .Unsigned(Unsigned), .Addr(Addr), .StoreData(StoreData), .LoadData(LoadData),
        .Stall(Stall), .Misaligned(Misaligned), .MisCount(MisCount), .MemA(MemA),
        .MemWE(MemWE), .MemWD(MemWD), .MemRD(MemRD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: little-endian byte/half extraction and insertion
    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic un, input logic [7:0] a);
        logic [31:0] v;
        int sh;
        if (sz == 2'd0) begin
            sh = 8 * int'(a[1:0]);
            v = (w >> sh) & 32'h0000_00FF;
            if (!un && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            sh = 16 * int'(a[1]);
            v = (w >> sh) & 32'h0000_FFFF;
            if (!un && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [7:0] a);
        logic [31:0] mask;
        int sh;
        sh   = (sz == 2'd1) ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
        mask = ((sz == 2'd1) ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    // Behavioural model state: expected memory image, pending sub-word write, miss counter
    logic [31:0] ref_mem [64];
    logic        hold = 1'b0;
    logic [5:0]  pend_a;
    logic [31:0] pend_val;
    int          cnt = 0;

    // Per-cycle compare of every output against the model
    always @(negedge CLK) begin
        logic mis_e, we_e, st_e;
        logic [31:0] ld_e, wd_e;
        logic [5:0] a_e;
        if (RST) begin
            chk("rst_stall", {31'd0, Stall}, 32'd0);
            chk("rst_we", {31'd0, MemWE}, 32'd0);
            chk("rst_miscount", {24'd0, MisCount}, 32'd0);
            hold = 1'b0;
            cnt  = 0;
        end else begin
            mis_e = !hold && (MemRead || MemWrite) &&
                    ((Size == 2'd1 && Addr[0]) || (Size[1] && Addr[1:0] != 2'd0));
            ld_e  = (MemRead && !mis_e) ? exp_load(ref_mem[Addr[7:2]], Size, Unsigned, Addr) : 32'd0;
            if (hold) begin
                we_e = 1'b1; st_e = 1'b0; wd_e = pend_val; a_e = pend_a;
            end else begin
                we_e = MemWrite && !mis_e && Size[1];
                st_e = MemWrite && !mis_e && !Size[1];
                wd_e = StoreData; a_e = Addr[7:2];
            end
            chk("m_load", LoadData, ld_e);
            chk("m_stall", {31'd0, Stall}, {31'd0, st_e});
            chk("m_we", {31'd0, MemWE}, {31'd0, we_e});
            chk("m_mis", {31'd0, Misaligned}, {31'd0, mis_e});
            chk("m_miscount", {24'd0, MisCount}, cnt);
            if (we_e) begin
                chk("m_mema", {26'd0, MemA}, {26'd0, a_e});
                chk("m_memwd", MemWD, wd_e);
            end
            if (mis_e && cnt < 255) cnt++;
            if (we_e) ref_mem[a_e] = wd_e;
            if (pre_we) ref_mem[pre_a] = pre_d;
            if (hold) begin
                hold = 1'b0;
            end else if (st_e) begin
                hold     = 1'b1;
                pend_a   = Addr[7:2];
                pend_val = exp_merge(ref_mem[Addr[7:2]], StoreData, Size, Addr);
            end
        end
    end

    // Results of the most recent request
    logic [31:0] r_ld, r_wd1, r_wd2;
    logic        r_st1, r_we1, r_mis, r_st2, r_we2;

    task automatic idle_inputs();
        MemRead = 1'b0; MemWrite = 1'b0; Size = 2'd0; Unsigned = 1'b0;
        Addr = 8'd0; StoreData = 32'd0;
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        @(posedge CLK); #1;
        pre_we = 1'b0;
    endtask

    // Present a request and hold it for as long as the pipeline would (two cycles for aligned sub-word stores)
    task automatic req(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                       input logic [7:0] a, input logic [31:0] d);
        logic sub;
        MemRead = rd; MemWrite = wr; Size = sz; Unsigned = un; Addr = a; StoreData = d;
        @(negedge CLK);
        r_ld = LoadData; r_st1 = Stall; r_we1 = MemWE; r_wd1 = MemWD; r_mis = Misaligned;
        r_st2 = 1'b0; r_we2 = 1'b0; r_wd2 = 32'd0;
        sub = wr && !sz[1] && !(sz == 2'd1 && a[0]);
        if (sub) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            r_st2 = Stall; r_we2 = MemWE; r_wd2 = MemWD;
        end
        @(posedge CLK); #1;
        idle_inputs();
    endtask

    initial begin
        RST = 1'b1; pre_we = 1'b0; pre_a = 6'd0; pre_d = 32'd0;
        idle_inputs();
        @(negedge CLK);
        chk("reset_miscount", {24'd0, MisCount}, 32'd0);
        chk("reset_mis", {31'd0, Misaligned}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int i = 0; i < 4; i++) preload(6'(i), 32'd0);

        // Load extension
        preload(6'd1, 32'h80FF_7F01);
        req(1, 0, 2'd0, 1, 8'h06, 0); chk("lbu06", r_ld, 32'h0000_00FF);
        req(1, 0, 2'd0, 0, 8'h06, 0); chk("lb06", r_ld, 32'hFFFF_FFFF);
        req(1, 0, 2'd0, 0, 8'h04, 0); chk("lb04", r_ld, 32'h0000_0001);
        req(1, 0, 2'd1, 0, 8'h06, 0); chk("lh06", r_ld, 32'hFFFF_80FF);
        req(1, 0, 2'd1, 1, 8'h06, 0); chk("lhu06", r_ld, 32'h0000_80FF);
        req(1, 0, 2'd2, 0, 8'h04, 0); chk("lw04", r_ld, 32'h80FF_7F01);

        // Byte store read-modify-write
        preload(6'd1, 32'h1122_3344);
        req(0, 1, 2'd0, 0, 8'h05, 32'h0000_00AB);
        chk("sb_stall1", {31'd0, r_st1}, 32'd1);
        chk("sb_we1", {31'd0, r_we1}, 32'd0);
        chk("sb_stall2", {31'd0, r_st2}, 32'd0);
        chk("sb_we2", {31'd0, r_we2}, 32'd1);
        chk("sb_wd2", r_wd2, 32'h1122_AB44);
        req(1, 0, 2'd2, 0, 8'h04, 0); chk("sb_readback", r_ld, 32'h1122_AB44);

        // Halfword store then word store
        preload(6'd1, 32'h1122_3344);
        req(0, 1, 2'd1, 0, 8'h06, 32'h0000_BEEF);
        chk("sh_wd2", r_wd2, 32'hBEEF_3344);
        chk("sh_mem", mem[1], 32'hBEEF_3344);
        req(0, 1, 2'd2, 0, 8'h08, 32'hCAFE_F00D);
        chk("sw_stall", {31'd0, r_st1}, 32'd0);
        chk("sw_we", {31'd0, r_we1}, 32'd1);
        chk("sw_mem", mem[2], 32'hCAFE_F00D);

        // Misaligned accesses
        req(1, 0, 2'd2, 0, 8'h06, 0);
        chk("lw06_mis", {31'd0, r_mis}, 32'd1);
        chk("lw06_ld", r_ld, 32'd0);
        req(0, 1, 2'd1, 0, 8'h03, 32'h0000_BEEF);
        chk("sh03_mis", {31'd0, r_mis}, 32'd1);
        chk("sh03_we", {31'd0, r_we1}, 32'd0);
        chk("sh03_stall", {31'd0, r_st1}, 32'd0);
        chk("mis_mem0", mem[0], 32'd0);
        chk("mis_mem1", mem[1], 32'hBEEF_3344);
        chk("miscount2", {24'd0, MisCount}, 32'd2);
        MemRead = 1'b1; Size = 2'd2; Addr = 8'h06;
        repeat (300) @(posedge CLK);
        #1; idle_inputs();
        chk("miscount_sat", {24'd0, MisCount}, 32'd255);

        // Reset during the write cycle of a byte store
        preload(6'd1, 32'h1122_3344);
        MemWrite = 1'b1; Size = 2'd0; Addr = 8'h04; StoreData = 32'h0000_00AB;
        @(negedge CLK);
        chk("rstw_stall1", {31'd0, Stall}, 32'd1);
        @(posedge CLK); #1;
        chk("rstw_we_pre", {31'd0, MemWE}, 32'd1);
        RST = 1'b1; #1;
        chk("rstw_we", {31'd0, MemWE}, 32'd0);
        @(negedge CLK);
        idle_inputs(); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("rstw_mem", mem[1], 32'h1122_3344);
        chk("rstw_miscount", {24'd0, MisCount}, 32'd0);
        req(0, 1, 2'd2, 0, 8'h10, 32'h0BAD_F00D);
        chk("rstw_idle_sw", {31'd0, r_we1}, 32'd1);
        req(1, 0, 2'd2, 0, 8'h04, 0); chk("rstw_lw", r_ld, 32'h1122_3344);

        // Simultaneous read and write
        preload(6'd3, 32'd0);
        req(1, 1, 2'd2, 0, 8'h0C, 32'h1234_5678);
        chk("rw_ld", r_ld, 32'd0);
        chk("rw_we", {31'd0, r_we1}, 32'd1);
        req(1, 0, 2'd2, 0, 8'h0C, 0); chk("rw_lw", r_ld, 32'h1234_5678);

        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store alignment stage placed between the datapath's memory-stage signals and the word-addressed 64×32 data memory. Turns byte-addressed, sized load and store requests into word accesses. Loads are extracted and sign- or zero-extended. Byte and halfword stores run as a two-cycle read-modify-write with a one-cycle stall, because the memory only writes whole words. Misaligned accesses are blocked and counted.

## Interface

- ADDR_W, 8, byte-address width; the word address is ADDR_W-2 bits (6 bits addresses 64 words).

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- Unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- Addr  in  ADDR_W  byte address.
- StoreData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- LoadData  out  32  extended load result.
- Stall  out  1  holds the pipeline for one cycle during a sub-word store.
- Misaligned  out  1  current request is misaligned.
- MisCount  out  8  saturating count of misaligned requests.
- MemA  out  ADDR_W-2  word address to data memory.
- MemWE  out  1  data memory write enable.
- MemWD  out  32  data memory write data.
- MemRD  in  32  data memory asynchronous read data.

## Operation

Byte order is little-endian: byte k of a word is bits [8k+7:8k], with k = Addr[1:0].

Misaligned is combinational. It is 1 when (MemRead|MemWrite) and either:
- halfword access with Addr[0] = 1, or
- word access with Addr[1:0] ≠ 00.

A misaligned request never asserts MemWE, forces LoadData = 0, and does not stall.

Loads are combinational and take one cycle:
- MemA = Addr[ADDR_W-1:2].
- Byte: select byte k and extend bit 7.
- Halfword: select bits [16h+15:16h], with h = Addr[1], and extend bit 15.
- Word: pass MemRD through.
- LoadData = 0 when MemRead = 0.

Word stores:
- Issued in IDLE: MemWE = 1, MemWD = StoreData, Stall = 0.

Sub-word stores use two states, IDLE and WRITE:
- IDLE, aligned byte/half store: Stall = 1, MemWE = 0.
  - Register merged = MemRD with the target byte/half replaced by StoreData's low bits.
  - Register waddr = Addr[ADDR_W-1:2].
  - Next state = WRITE.
- WRITE: MemA = waddr, MemWD = merged, MemWE = 1, Stall = 0; next state = IDLE. Request inputs in this cycle are the held store and are ignored.

Simultaneous MemRead and MemWrite:
- The store is performed.
- LoadData still reflects the pre-write MemRD.

MisCount:
- Increments on each rising edge where Misaligned = 1 and the state is IDLE.
- Saturates at 255.

## Timing

- Reset values: state IDLE, merged 0, waddr 0, MisCount 0. With no request active, Stall, MemWE and Misaligned are all 0.
- Load latency: 0 cycles (combinational through MemRD).
- Word store: the write lands at the rising edge that ends the request cycle.
- Sub-word store: occupies 2 cycles.
  - Cycle 1: Stall = 1.
  - Cycle 2: MemWE = 1.
  - The write lands at the edge ending cycle 2, and the pipeline advances at that same edge.
- Back-to-back sub-word stores:
  - Each costs 2 cycles.
  - The second store's read in its cycle 1 sees the first store's data (written at the preceding edge).
- RST asserted in WRITE: immediately IDLE and MemWE = 0. The pending write is dropped and the memory is left unmodified.
- RST overrides all inputs. MisCount is not cleared by anything but RST.

## Test plan

1. Load extension, with the word at byte 0x04 = 0x80FF7F01:
   - lbu 0x06 -> 0x000000FF
   - lb 0x06 -> 0xFFFFFFFF
   - lb 0x04 -> 0x00000001
   - lh 0x06 -> 0xFFFF80FF
   - lhu 0x06 -> 0x000080FF
   - lw 0x04 -> 0x80FF7F01
2. Byte store, with word 0x04 = 0x11223344: sb 0x000000AB at 0x05 -> Stall = 1 for exactly one cycle, then MemWE = 1 with MemWD = 0x1122AB44; the word then reads 0x1122AB44.
3. Halfword store followed by word store: sh 0xBEEF at 0x06 -> word = 0xBEEF3344 after 2 cycles; the following sw 0xCAFEF00D at 0x08 -> written in 1 cycle with no stall.
4. Misaligned accesses:
   - lw 0x06 and sh 0x03 -> Misaligned = 1, LoadData = 0, MemWE never 1, memory unchanged, MisCount = 2.
   - 300 consecutive misaligned cycles -> MisCount = 255.
5. Reset in WRITE: sb 0xAB at 0x04 with RST pulsed during cycle 2 -> MemWE falls at once, the word keeps its old value, state IDLE, MisCount = 0.
6. Simultaneous MemRead = MemWrite = 1, sw 0x12345678 at 0x0C over an old value of 0 -> LoadData = 0 that cycle; the next lw 0x0C returns 0x12345678.
